bnn_host_ctrl: RTL

Host-side sequencer that drives the `bnn` accelerator's load/start/readback interface. It accepts a 784-pixel image over a valid/ready byte stream and writes it into the accelerator's activation input memory. It then pulses start, waits for done, reads the 10 signed class scores from the output region, and presents the argmax class and its score on a result handshake. It sits between an image source (DMA, UART bridge) and `bnn`, replacing bench-driven stimulus in the system build.

---
 rtl/bnn_host_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/bnn_host_ctrl.sv
// Host sequencer for bnn: loads one image, pulses start, waits for done, reads the scores back.
// One pixel per cycle while loading, result held on a valid/ready handshake until taken.
module bnn_host_ctrl #(
    parameter int N_PIX     = 784,
    parameter int N_CLASS   = 10,
    parameter int OUT_BASE  = 1024,
    parameter int ADDR_W    = 11,
    parameter int RD_LAT    = 2,
    parameter int START_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_valid,
    input  logic [7:0]        pix_data,
    output logic              pix_ready,
    output logic              bnn_wr_en,
    output logic [ADDR_W-1:0] bnn_wr_addr,
    output logic [7:0]        bnn_wr_data,
    output logic              bnn_start,
    input  logic              bnn_done,
    output logic [ADDR_W-1:0] bnn_rd_addr,
    input  logic [7:0]        bnn_rd_data,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [3:0]        result_class,
    output logic [7:0]        result_score,
    output logic              busy
);
    localparam int CNT_W = $clog2(N_PIX + 1);
    localparam int PH_W  = $clog2(RD_LAT + 1);
    localparam int SC_W  = $clog2(START_CYC + 1);

    localparam logic [2:0] S_LOAD   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_READ   = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SC_W-1:0]   sc_q, sc_d;
    logic [3:0]        idx_q, idx_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic signed [7:0] best_q, best_d;
    logic [3:0]        best_idx_q, best_idx_d;

    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              start_q, start_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rv_q, rv_d;
    logic [3:0]        cls_q, cls_d;
    logic [7:0]        score_q, score_d;

    logic              accept;
    logic signed [7:0] cap_score;

    assign pix_ready = (state_q == S_LOAD);
    assign busy      = !((state_q == S_LOAD) && (cnt_q == '0));
    assign accept    = pix_valid && pix_ready;
    assign cap_score = $signed(bnn_rd_data);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sc_d       = sc_q;
        idx_d      = idx_q;
        ph_d       = ph_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        start_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        rv_d       = rv_q;
        cls_d      = cls_q;
        score_d    = score_q;

        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ADDR_W'(cnt_q);
                    wr_data_d = pix_data;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N_PIX - 1)) begin
                        state_d = S_START;
                    end
                end
            end

            S_START: begin
                // First START cycle carries the final write; the pulse follows it.
                if (sc_q != SC_W'(START_CYC)) begin
                    start_d = 1'b1;
                    sc_d    = sc_q + SC_W'(1);
                end else begin
                    sc_d    = '0;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (bnn_done) begin
                    state_d = S_READ;
                    idx_d   = '0;
                    ph_d    = '0;
                end
            end

            S_READ: begin
                if (ph_q == '0) begin
                    rd_addr_d = ADDR_W'(OUT_BASE) + ADDR_W'(idx_q);
                end
                if (ph_q == PH_W'(RD_LAT)) begin
                    ph_d = '0;
                    // Strict greater-than keeps the lowest index on ties.
                    if ((idx_q == '0) || (cap_score > best_q)) begin
                        best_d     = cap_score;
                        best_idx_d = idx_q;
                    end
                    if (idx_q == 4'(N_CLASS - 1)) begin
                        state_d = S_RESULT;
                        rv_d    = 1'b1;
                        cls_d   = best_idx_d;
                        score_d = best_d;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end

            S_RESULT: begin
                if (result_ready) begin
                    rv_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end

            default: begin
                state_d = S_LOAD;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_LOAD;
            cnt_q      <= '0;
            sc_q       <= '0;
            idx_q      <= '0;
            ph_q       <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            start_q    <= 1'b0;
            rd_addr_q  <= '0;
            rv_q       <= 1'b0;
            cls_q      <= '0;
            score_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sc_q       <= sc_d;
            idx_q      <= idx_d;
            ph_q       <= ph_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            start_q    <= start_d;
            rd_addr_q  <= rd_addr_d;
            rv_q       <= rv_d;
            cls_q      <= cls_d;
            score_q    <= score_d;
        end
    end

    assign bnn_wr_en    = wr_en_q;
    assign bnn_wr_addr  = wr_addr_q;
    assign bnn_wr_data  = wr_data_q;
    assign bnn_start    = start_q;
    assign bnn_rd_addr  = rd_addr_q;
    assign result_valid = rv_q;
    assign result_class = cls_q;
    assign result_score = score_q;

endmodule
